rs_dispatch_unit: RTL and testbench

- Add/sub reservation station with issue sequencer; it is the producer side of the adder execution-unit interface.
- Accepts decoded ops from the issue stage and holds up to DEPTH entries.
- Snoops result broadcasts on the CDB to capture missing operands.
- Dispatches the oldest fully-ready entry to the execution unit. An entry is released only when the unit signals completion, so occupancy matches the RS count convention.

---
 rtl/rs_dispatch_unit.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_rs_dispatch_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_dispatch_unit.sv
// -----------------------------------------------------------------------------
// rs_dispatch_unit
//
// Add/sub reservation station with a two-state issue sequencer. It is the
// producer side of the adder execution-unit interface.
//
//   - Holds up to DEPTH decoded ops from the issue stage.
//   - Snoops CDB broadcasts to capture missing source operands.
//   - Dispatches the oldest fully-ready entry. Ties go to the lowest index.
//   - Keeps the dispatched entry (inflight) until the execution unit pulses
//     ex_done, so rs_count always includes the op in flight.
//
// Handshakes:
//   issue    : an op is accepted on a rising edge where iss_valid && iss_ready.
//              iss_ready depends only on the registered rs_count, never on
//              anything freed in the same cycle.
//   dispatch : ex_b is a one-cycle strobe. src1_data/src2_data/func/rdest are
//              valid with it and held until the next dispatch.
//   complete : ex_done is a one-cycle pulse. It is meaningful only while busy.
//              In IDLE it sets the sticky err_spurious flag.
//
// Ports:
//   clock1, rst_n                    clock, asynchronous active-low reset
//   iss_valid/iss_ready              issue handshake
//   iss_func, iss_rdest              opcode (0000 add, 0001 sub), destination
//   iss_srcN_rdy/_tag/_val           source N: ready flag, producer tag, value
//   cdb_valid/cdb_tag/cdb_data       result broadcast bus
//   ex_b                             dispatch strobe
//   src1_data, src2_data, func,      dispatched payload
//   rdest
//   ex_done                          completion pulse from the execution unit
//   rs_count                         occupied entries (in-flight included)
//   busy                             FSM is in BUSY (this is the state bit)
//   err_spurious                     sticky: ex_done seen while IDLE
//
// Optional feature (macro RS_CDB_BYPASS_EN):
//   When defined, an IDLE entry whose last missing operand matches the
//   current CDB broadcast is a candidate in that same cycle. The operand is
//   then taken directly from cdb_data.
// -----------------------------------------------------------------------------
module rs_dispatch_unit #(
  parameter int DEPTH  = 3,
  parameter int DATA_W = 8,
  parameter int TAG_W  = 4,
  parameter int FUNC_W = 4,
  parameter int AGE_W  = 4
) (
  input  logic                           clock1,
  input  logic                           rst_n,
  input  logic                           iss_valid,
  output logic                           iss_ready,
  input  logic [FUNC_W-1:0]              iss_func,
  input  logic [TAG_W-1:0]               iss_rdest,
  input  logic                           iss_src1_rdy,
  input  logic [TAG_W-1:0]               iss_src1_tag,
  input  logic [DATA_W-1:0]              iss_src1_val,
  input  logic                           iss_src2_rdy,
  input  logic [TAG_W-1:0]               iss_src2_tag,
  input  logic [DATA_W-1:0]              iss_src2_val,
  input  logic                           cdb_valid,
  input  logic [TAG_W-1:0]               cdb_tag,
  input  logic [DATA_W-1:0]              cdb_data,
  output logic                           ex_b,
  output logic [DATA_W-1:0]              src1_data,
  output logic [DATA_W-1:0]              src2_data,
  output logic [FUNC_W-1:0]              func,
  output logic [TAG_W-1:0]               rdest,
  input  logic                           ex_done,
  output logic [$clog2(DEPTH+1)-1:0]     rs_count,
  output logic                           busy,
  output logic                           err_spurious
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_inflight;
  logic [DEPTH-1:0]  r_rdy1;
  logic [DEPTH-1:0]  r_rdy2;
  logic [FUNC_W-1:0] r_func  [DEPTH];
  logic [TAG_W-1:0]  r_rdest [DEPTH];
  logic [TAG_W-1:0]  r_tag1  [DEPTH];
  logic [TAG_W-1:0]  r_tag2  [DEPTH];
  logic [DATA_W-1:0] r_val1  [DEPTH];
  logic [DATA_W-1:0] r_val2  [DEPTH];
  logic [AGE_W-1:0]  r_age   [DEPTH];

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_count;
  logic [IDX_W-1:0]  r_fl_idx;      // index of the entry in flight
  logic              r_ex_b;
  logic [DATA_W-1:0] r_src1_data;
  logic [DATA_W-1:0] r_src2_data;
  logic [FUNC_W-1:0] r_func_out;
  logic [TAG_W-1:0]  r_rdest_out;
  logic              r_err_spurious;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic              w_issue;
  logic [IDX_W-1:0]  w_free_idx;
  logic              w_iss_cap1;
  logic              w_iss_cap2;
  logic [DEPTH-1:0]  w_cap1;
  logic [DEPTH-1:0]  w_cap2;
  logic [DEPTH-1:0]  w_cand;
  logic              w_found;
  logic [IDX_W-1:0]  w_sel;
  logic [AGE_W-1:0]  w_best_age;
  logic [DATA_W-1:0] w_sel_v1;
  logic [DATA_W-1:0] w_sel_v2;
  logic [FUNC_W-1:0] w_sel_func;
  logic [TAG_W-1:0]  w_sel_rdest;
  logic              w_dispatch;
  logic              w_complete;
  logic              w_spurious;

  assign iss_ready = (r_count < CNT_W'(DEPTH));
  assign w_issue   = iss_valid && iss_ready;

  // An op being issued can capture a broadcast in its very first cycle.
  assign w_iss_cap1 = cdb_valid && !iss_src1_rdy && (iss_src1_tag == cdb_tag);
  assign w_iss_cap2 = cdb_valid && !iss_src2_rdy && (iss_src2_tag == cdb_tag);

  // Lowest-index free slot. The scan runs downward so the lowest index wins.
  // iss_ready guarantees a free slot exists whenever w_issue is set.
  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
    end
  end

  // Snoop matches and dispatch candidates.
  always_comb begin
    w_cap1 = '0;
    w_cap2 = '0;
    w_cand = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cap1[i] = cdb_valid && r_valid[i] && !r_rdy1[i] && (r_tag1[i] == cdb_tag);
      w_cap2[i] = cdb_valid && r_valid[i] && !r_rdy2[i] && (r_tag2[i] == cdb_tag);
`ifdef RS_CDB_BYPASS_EN
      w_cand[i] = r_valid[i] && !r_inflight[i] &&
                  (r_rdy1[i] || w_cap1[i]) && (r_rdy2[i] || w_cap2[i]);
`else
      w_cand[i] = r_valid[i] && !r_inflight[i] && r_rdy1[i] && r_rdy2[i];
`endif
    end
  end

  // Oldest-candidate select. The strict '>' keeps the lowest index on equal age.
  always_comb begin
    w_found     = 1'b0;
    w_sel       = '0;
    w_best_age  = '0;
    w_sel_v1    = '0;
    w_sel_v2    = '0;
    w_sel_func  = '0;
    w_sel_rdest = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_cand[i] && (!w_found || (r_age[i] > w_best_age))) begin
        w_found     = 1'b1;
        w_sel       = IDX_W'(i);
        w_best_age  = r_age[i];
        w_sel_func  = r_func[i];
        w_sel_rdest = r_rdest[i];
`ifdef RS_CDB_BYPASS_EN
        w_sel_v1    = w_cap1[i] ? cdb_data : r_val1[i];
        w_sel_v2    = w_cap2[i] ? cdb_data : r_val2[i];
`else
        w_sel_v1    = r_val1[i];
        w_sel_v2    = r_val2[i];
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock1 or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_BUSY;
      S_BUSY:  if (ex_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs (decoded actions)
  always_comb begin
    w_dispatch = 1'b0;
    w_complete = 1'b0;
    w_spurious = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_dispatch = w_found;
        w_spurious = ex_done;
      end
      S_BUSY: begin
        w_complete = ex_done;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Entry array update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock1 or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= '0;
      r_inflight <= '0;
      r_rdy1     <= '0;
      r_rdy2     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_func[i]  <= '0;
        r_rdest[i] <= '0;
        r_tag1[i]  <= '0;
        r_tag2[i]  <= '0;
        r_val1[i]  <= '0;
        r_val2[i]  <= '0;
        r_age[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_complete && (r_fl_idx == IDX_W'(i))) begin
          r_valid[i]    <= 1'b0;
          r_inflight[i] <= 1'b0;
        end else if (w_issue && (w_free_idx == IDX_W'(i))) begin
          r_valid[i]    <= 1'b1;
          r_inflight[i] <= 1'b0;
          r_func[i]     <= iss_func;
          r_rdest[i]    <= iss_rdest;
          r_tag1[i]     <= iss_src1_tag;
          r_tag2[i]     <= iss_src2_tag;
          r_rdy1[i]     <= iss_src1_rdy || w_iss_cap1;
          r_rdy2[i]     <= iss_src2_rdy || w_iss_cap2;
          r_val1[i]     <= w_iss_cap1 ? cdb_data : iss_src1_val;
          r_val2[i]     <= w_iss_cap2 ? cdb_data : iss_src2_val;
          r_age[i]      <= '0;
        end else if (r_valid[i]) begin
          if (w_cap1[i]) begin
            r_rdy1[i] <= 1'b1;
            r_val1[i] <= cdb_data;
          end
          if (w_cap2[i]) begin
            r_rdy2[i] <= 1'b1;
            r_val2[i] <= cdb_data;
          end
          if (!r_inflight[i] && (r_age[i] != AGE_MAX)) r_age[i] <= r_age[i] + AGE_W'(1);
          if (w_dispatch && (w_sel == IDX_W'(i))) r_inflight[i] <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy, dispatch registers, error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock1 or negedge rst_n) begin
    if (!rst_n) begin
      r_count        <= '0;
      r_fl_idx       <= '0;
      r_ex_b         <= 1'b0;
      r_src1_data    <= '0;
      r_src2_data    <= '0;
      r_func_out     <= '0;
      r_rdest_out    <= '0;
      r_err_spurious <= 1'b0;
    end else begin
      // Issue and completion in the same cycle cancel out.
      if (w_issue && !w_complete)      r_count <= r_count + CNT_W'(1);
      else if (!w_issue && w_complete) r_count <= r_count - CNT_W'(1);

      r_ex_b <= w_dispatch;
      if (w_dispatch) begin
        r_fl_idx    <= w_sel;
        r_src1_data <= w_sel_v1;
        r_src2_data <= w_sel_v2;
        r_func_out  <= w_sel_func;
        r_rdest_out <= w_sel_rdest;
      end

      if (w_spurious) r_err_spurious <= 1'b1;
    end
  end

  assign ex_b         = r_ex_b;
  assign src1_data    = r_src1_data;
  assign src2_data    = r_src2_data;
  assign func         = r_func_out;
  assign rdest        = r_rdest_out;
  assign rs_count     = r_count;
  assign busy         = (r_state == S_BUSY);
  assign err_spurious = r_err_spurious;

endmodule

// File: tb/tb_rs_dispatch_unit.sv
// -----------------------------------------------------------------------------
// tb_rs_dispatch_unit
//
// Directed bench for rs_dispatch_unit using the default parameters.
// The stimulus process pushes each expected dispatch {func, rdest, src1, src2}
// onto exp_q, in the order the dispatches should appear. A monitor pops and
// compares on every ex_b strobe. Timing, occupancy and flag checks are made
// inline by the stimulus process.
// -----------------------------------------------------------------------------
module tb_rs_dispatch_unit;

  localparam int W = 24;   // {func[4], rdest[4], src1[8], src2[8]}

`ifdef RS_CDB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic       clock1;
  logic       rst_n;
  logic       iss_valid;
  logic       iss_ready;
  logic [3:0] iss_func;
  logic [3:0] iss_rdest;
  logic       iss_src1_rdy;
  logic [3:0] iss_src1_tag;
  logic [7:0] iss_src1_val;
  logic       iss_src2_rdy;
  logic [3:0] iss_src2_tag;
  logic [7:0] iss_src2_val;
  logic       cdb_valid;
  logic [3:0] cdb_tag;
  logic [7:0] cdb_data;
  logic       ex_b;
  logic [7:0] src1_data;
  logic [7:0] src2_data;
  logic [3:0] func;
  logic [3:0] rdest;
  logic       ex_done;
  logic [1:0] rs_count;
  logic       busy;
  logic       err_spurious;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  rs_dispatch_unit dut (
    .clock1       (clock1),
    .rst_n        (rst_n),
    .iss_valid    (iss_valid),
    .iss_ready    (iss_ready),
    .iss_func     (iss_func),
    .iss_rdest    (iss_rdest),
    .iss_src1_rdy (iss_src1_rdy),
    .iss_src1_tag (iss_src1_tag),
    .iss_src1_val (iss_src1_val),
    .iss_src2_rdy (iss_src2_rdy),
    .iss_src2_tag (iss_src2_tag),
    .iss_src2_val (iss_src2_val),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .ex_b         (ex_b),
    .src1_data    (src1_data),
    .src2_data    (src2_data),
    .func         (func),
    .rdest        (rdest),
    .ex_done      (ex_done),
    .rs_count     (rs_count),
    .busy         (busy),
    .err_spurious (err_spurious)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial begin
    clock1 = 1'b0;
    forever #5 clock1 = ~clock1;
  end

  // ---------------------------------------------------------------------------
  // Helpers / driver tasks
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock1);
    #1;
  endtask

  function automatic logic [W-1:0] pack(input logic [3:0] f, input logic [3:0] rd,
                                        input logic [7:0] a, input logic [7:0] b);
    return {f, rd, a, b};
  endfunction

  // Holds the op on the issue port until it is accepted, then releases it.
  task automatic issue_op(input logic [3:0] f, input logic [3:0] rd,
                          input logic r1, input logic [3:0] t1, input logic [7:0] v1,
                          input logic r2, input logic [3:0] t2, input logic [7:0] v2);
    int n;
    iss_func     = f;
    iss_rdest    = rd;
    iss_src1_rdy = r1;
    iss_src1_tag = t1;
    iss_src1_val = v1;
    iss_src2_rdy = r2;
    iss_src2_tag = t2;
    iss_src2_val = v2;
    iss_valid    = 1'b1;
    n = 0;
    while (!iss_ready && n < 50) begin
      tick();
      n++;
    end
    if (!iss_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: iss_ready stayed 0 for rdest %0h", rd);
    end
    @(posedge clock1);
    #1;
    iss_valid = 1'b0;
  endtask

  task automatic broadcast(input logic [3:0] t, input logic [7:0] d);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    cdb_data  = d;
    tick();
    cdb_valid = 1'b0;
  endtask

  task automatic pulse_done();
    ex_done = 1'b1;
    tick();
    ex_done = 1'b0;
  endtask

  // Returns with ex_b high in the current cycle, or records a timeout.
  task automatic wait_exb(input string name, input int budget);
    int n;
    n = 0;
    while (!ex_b && n < budget) begin
      tick();
      n++;
    end
    check(name, {31'd0, ex_b}, 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitor
  // ---------------------------------------------------------------------------
  always @(negedge clock1) begin
    if (rst_n && ex_b) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL dispatch_unexpected: got %0h expected none", {func, rdest, src1_data, src2_data});
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({func, rdest, src1_data, src2_data} !== e) begin
          n_fail++;
          $display("FAIL dispatch_payload: got %0h expected %0h", {func, rdest, src1_data, src2_data}, e);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    iss_valid = 0; iss_func = 0; iss_rdest = 0;
    iss_src1_rdy = 0; iss_src1_tag = 0; iss_src1_val = 0;
    iss_src2_rdy = 0; iss_src2_tag = 0; iss_src2_val = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    ex_done = 0;

    // Reset values
    tick();
    tick();
    check("rst_ex_b",      {31'd0, ex_b}, 32'd0);
    check("rst_payload",   {8'd0, func, rdest, src1_data, src2_data}, 32'd0);
    check("rst_count",     {30'd0, rs_count}, 32'd0);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    check("rst_err",       {31'd0, err_spurious}, 32'd0);
    check("rst_iss_ready", {31'd0, iss_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Test 1: add r3 = 5 + 7, both ready
    exp_q.push_back(pack(4'h0, 4'h3, 8'd5, 8'd7));
    issue_op(4'h0, 4'h3, 1'b1, 4'h0, 8'd5, 1'b1, 4'h0, 8'd7);
    check("t1_count_after_issue", {30'd0, rs_count}, 32'd1);
    check("t1_no_ex_b_at_issue",  {31'd0, ex_b}, 32'd0);
    tick();
    check("t1_ex_b_next_edge",    {31'd0, ex_b}, 32'd1);
    check("t1_busy",              {31'd0, busy}, 32'd1);
    tick();
    check("t1_strobe_one_cycle",  {31'd0, ex_b}, 32'd0);
    check("t1_operands_held",     {16'd0, src1_data, src2_data}, 32'h0507);
    tick();
    tick();
    pulse_done();
    check("t1_count_after_done",  {30'd0, rs_count}, 32'd0);
    check("t1_idle_after_done",   {31'd0, busy}, 32'd0);

    // Test 2: sub r4, src1 waits on tag 2, src2 = 1
    exp_q.push_back(pack(4'h1, 4'h4, 8'd9, 8'd1));
    issue_op(4'h1, 4'h4, 1'b0, 4'h2, 8'h33, 1'b1, 4'h0, 8'd1);
    tick();
    tick();
    check("t2_waits_for_operand", {31'd0, ex_b}, 32'd0);
    broadcast(4'h2, 8'd9);
    check("t2_ex_b_after_M",      {31'd0, ex_b}, {31'd0, BYP});
    tick();
    check("t2_ex_b_after_M1",     {31'd0, ex_b}, {31'd0, ~BYP});
    pulse_done();
    check("t2_count_after_done",  {30'd0, rs_count}, 32'd0);

    // Test 3: fill with three ops waiting on tag 6, then hold a fourth
    exp_q.push_back(pack(4'h0, 4'h1, 8'h10, 8'd2));
    exp_q.push_back(pack(4'h0, 4'h2, 8'h10, 8'd3));
    exp_q.push_back(pack(4'h1, 4'h5, 8'h10, 8'd4));
    exp_q.push_back(pack(4'h0, 4'h7, 8'd1, 8'd1));
    issue_op(4'h0, 4'h1, 1'b0, 4'h6, 8'h00, 1'b1, 4'h0, 8'd2);
    issue_op(4'h0, 4'h2, 1'b0, 4'h6, 8'h00, 1'b1, 4'h0, 8'd3);
    issue_op(4'h1, 4'h5, 1'b0, 4'h6, 8'h00, 1'b1, 4'h0, 8'd4);
    check("t3_full_not_ready", {31'd0, iss_ready}, 32'd0);
    check("t3_full_count",     {30'd0, rs_count}, 32'd3);
    iss_func = 4'h0; iss_rdest = 4'h7;
    iss_src1_rdy = 1'b1; iss_src1_tag = 4'h0; iss_src1_val = 8'd1;
    iss_src2_rdy = 1'b1; iss_src2_tag = 4'h0; iss_src2_val = 8'd1;
    iss_valid = 1'b1;
    tick();
    tick();
    check("t3_fourth_held", {30'd0, rs_count}, 32'd3);
    broadcast(4'h6, 8'h10);
    wait_exb("t3_first_dispatch", 5);
    check("t3_not_ready_while_busy", {31'd0, iss_ready}, 32'd0);
    pulse_done();
    check("t3_ready_after_done", {31'd0, iss_ready}, 32'd1);
    check("t3_count_after_done", {30'd0, rs_count}, 32'd2);
    tick();
    iss_valid = 1'b0;
    check("t3_fourth_accepted", {30'd0, rs_count}, 32'd3);
    wait_exb("t3_second_dispatch", 5);
    pulse_done();
    wait_exb("t3_third_dispatch", 5);
    pulse_done();
    wait_exb("t3_fourth_dispatch", 5);
    pulse_done();
    check("t3_drained", {30'd0, rs_count}, 32'd0);

    // Test 4: entry 2 is older than entries 0 and 1 refilled later
    exp_q.push_back(pack(4'h0, 4'h1, 8'd1, 8'd1));   // A, entry 0
    exp_q.push_back(pack(4'h0, 4'h2, 8'd2, 8'd2));   // B, entry 1
    exp_q.push_back(pack(4'h1, 4'h3, 8'h20, 8'd1));  // C, entry 2 (oldest)
    exp_q.push_back(pack(4'h0, 4'h8, 8'h20, 8'd3));  // D, entry 0
    exp_q.push_back(pack(4'h0, 4'h9, 8'h20, 8'd5));  // E, entry 1
    issue_op(4'h0, 4'h1, 1'b1, 4'h0, 8'd1, 1'b1, 4'h0, 8'd1);
    issue_op(4'h0, 4'h2, 1'b1, 4'h0, 8'd2, 1'b1, 4'h0, 8'd2);
    issue_op(4'h1, 4'h3, 1'b0, 4'h7, 8'h00, 1'b1, 4'h0, 8'd1);
    check("t4_busy_with_a", {31'd0, busy}, 32'd1);
    pulse_done();
    wait_exb("t4_b_dispatch", 5);
    pulse_done();
    issue_op(4'h0, 4'h8, 1'b0, 4'h7, 8'h00, 1'b1, 4'h0, 8'd3);
    issue_op(4'h0, 4'h9, 1'b0, 4'h7, 8'h00, 1'b1, 4'h0, 8'd5);
    check("t4_three_waiting", {30'd0, rs_count}, 32'd3);
    broadcast(4'h7, 8'h20);
    for (int k = 0; k < 3; k++) begin
      wait_exb("t4_age_dispatch", 5);
      pulse_done();
    end
    check("t4_drained", {30'd0, rs_count}, 32'd0);

    // Test 5: capture on the issue cycle itself
    exp_q.push_back(pack(4'h0, 4'h6, 8'd3, 8'hAA));
    cdb_valid = 1'b1; cdb_tag = 4'h5; cdb_data = 8'hAA;
    issue_op(4'h0, 4'h6, 1'b1, 4'h0, 8'd3, 1'b0, 4'h5, 8'h55);
    cdb_valid = 1'b0;
    tick();
    check("t5_dispatch_no_rebroadcast", {31'd0, ex_b}, 32'd1);
    pulse_done();

    // Test 6: issue and completion on the same edge; unknown opcode passes through
    exp_q.push_back(pack(4'h1, 4'hA, 8'd9, 8'd4));
    exp_q.push_back(pack(4'hC, 4'hB, 8'd6, 8'd6));
    issue_op(4'h1, 4'hA, 1'b1, 4'h0, 8'd9, 1'b1, 4'h0, 8'd4);
    tick();
    check("t6_x_dispatch", {31'd0, ex_b}, 32'd1);
    ex_done = 1'b1;
    issue_op(4'hC, 4'hB, 1'b1, 4'h0, 8'd6, 1'b1, 4'h0, 8'd6);
    ex_done = 1'b0;
    check("t6_count_unchanged", {30'd0, rs_count}, 32'd1);
    wait_exb("t6_y_dispatch", 5);
    pulse_done();
    check("t6_drained", {30'd0, rs_count}, 32'd0);

    // Test 7: reset while BUSY, then a stray ex_done
    exp_q.push_back(pack(4'h0, 4'hC, 8'd2, 8'd3));
    issue_op(4'h0, 4'hC, 1'b1, 4'h0, 8'd2, 1'b1, 4'h0, 8'd3);
    tick();
    tick();
    check("t7_busy_before_reset", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_outputs", {8'd0, func, rdest, src1_data, src2_data}, 32'd0);
    check("t7_rst_flags",   {28'd0, ex_b, busy, rs_count}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t7_err_clear", {31'd0, err_spurious}, 32'd0);
    pulse_done();
    check("t7_err_spurious", {31'd0, err_spurious}, 32'd1);
    check("t7_no_dispatch",  {31'd0, ex_b}, 32'd0);
    check("t7_idle",         {29'd0, busy, rs_count}, 32'd0);
    tick();
    tick();
    check("t7_err_sticky", {31'd0, err_spurious}, 32'd1);
    check("t7_still_no_dispatch", {31'd0, ex_b}, 32'd0);

    // Final report
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound in case a wait slips through.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule
